// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the main-memory arbiter
// Provides the arbiter FSM state encoding, requester ids and default bus widths.
package mem_pkg;

  localparam int ADDR_W_DEF      = 32;
  localparam int LINE_W_DEF      = 128;
  localparam int MEM_LATENCY_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Requester ids; also the bit positions inside the packed request vector.
  localparam logic GRANT_IC = 1'b0;
  localparam logic GRANT_DC = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - icache/dcache/memory signal bundle around mem_arbiter
// slave modport: arbiter view (cache requests and mem_rdata in; acks, rdata, mem_* out).
// master modport: environment view (caches plus memory model).
interface mem_arbiter_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) ();

  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_ack;
  logic [LINE_W-1:0] ic_rdata;

  logic              dc_req;
  logic              dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [LINE_W-1:0] dc_wdata;
  logic              dc_ack;
  logic [LINE_W-1:0] dc_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;

  modport slave (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata,
    output ic_ack, ic_rdata, dc_ack, dc_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata,
    input  ic_ack, ic_rdata, dc_ack, dc_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin picker
// Ports: req[1:0] (bit GRANT_IC = icache, bit GRANT_DC = dcache), last_grant in;
// grant_id out. Purely combinational; the caller owns last_grant.
module rr_arb2
  import mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_id
);

  always_comb begin
    grant_id = GRANT_IC;
    case (req)
      2'b10:   grant_id = GRANT_DC;
      // On a tie the requester served less recently wins.
      2'b11:   grant_id = ~last_grant;
      default: grant_id = GRANT_IC;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one fixed-latency memory port between icache and dcache
// Ports: clk, reset (sync, active low), bus (mem_arbiter_if.slave) carrying the
// icache read request, dcache read/write-back request, their acks and read lines,
// and the memory-side request/address/data.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int LINE_W      = LINE_W_DEF,
  parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int             CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [LINE_W-1:0] ic_rdata_q, ic_rdata_d;
  logic [LINE_W-1:0] dc_rdata_q, dc_rdata_d;
  logic              ic_ack_q, ic_ack_d;
  logic              dc_ack_q, dc_ack_d;

  logic [1:0]        req_vec;
  logic              win_id;

  assign req_vec = {bus.dc_req, bus.ic_req};

  rr_arb2 u_rr_arb2 (
    .req        (req_vec),
    .last_grant (last_grant_q),
    .grant_id   (win_id)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    ic_rdata_d   = ic_rdata_q;
    dc_rdata_d   = dc_rdata_q;
    ic_ack_d     = 1'b0;
    dc_ack_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req_vec) begin
          state_d      = ST_ACCESS;
          cnt_d        = CNT_INIT;
          grant_d      = win_id;
          last_grant_d = win_id;
          mem_req_d    = 1'b1;
          if (win_id == GRANT_DC) begin
            mem_we_d    = bus.dc_we;
            mem_addr_d  = bus.dc_addr;
            mem_wdata_d = bus.dc_wdata;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.ic_addr;
            mem_wdata_d = '0;
          end
        end
      end

      ST_ACCESS: begin
        if (cnt_q == '0) begin
          // Last memory cycle: mem_rdata is valid now, so capture it here and
          // raise the ack, which lands in the DONE cycle.
          state_d   = ST_DONE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (grant_q == GRANT_DC) begin
            dc_ack_d = 1'b1;
            if (!mem_we_q) dc_rdata_d = bus.mem_rdata;
          end else begin
            ic_ack_d   = 1'b1;
            ic_rdata_d = bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      // Requests are ignored here so the just-served cache can drop req.
      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      grant_q      <= GRANT_IC;
      last_grant_q <= GRANT_IC;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      ic_rdata_q   <= '0;
      dc_rdata_q   <= '0;
      ic_ack_q     <= 1'b0;
      dc_ack_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      ic_rdata_q   <= ic_rdata_d;
      dc_rdata_q   <= dc_rdata_d;
      ic_ack_q     <= ic_ack_d;
      dc_ack_q     <= dc_ack_d;
    end
  end

  assign bus.ic_ack    = ic_ack_q;
  assign bus.ic_rdata  = ic_rdata_q;
  assign bus.dc_ack    = dc_ack_q;
  assign bus.dc_rdata  = dc_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int AW  = 32;
  localparam int LW  = 128;
  localparam int LAT = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();
  mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus1 ();

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  assign bus1.ic_req    = bus.ic_req;
  assign bus1.ic_addr   = bus.ic_addr;
  assign bus1.dc_req    = bus.dc_req;
  assign bus1.dc_we     = bus.dc_we;
  assign bus1.dc_addr   = bus.dc_addr;
  assign bus1.dc_wdata  = bus.dc_wdata;
  assign bus1.mem_rdata = bus.mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 128'(act), 128'(exp));
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    chk(name, 128'(act), 128'(exp));
  endtask

  // Transaction-level reference: a grant opens a transaction at offset 0;
  // mem_req covers offsets 0..LAT-1, the ack lands at offset LAT, and the
  // arbiter is free to grant again one edge later.
  logic          e_mem_req, e_mem_we, e_ic_ack, e_dc_ack;
  logic [AW-1:0] e_mem_addr;
  logic [LW-1:0] e_mem_wdata, e_ic_rdata, e_dc_rdata;
  bit            busy, model_valid, rst_ok;
  int            t;
  logic          cur_who, cur_we, last_who;
  bit            grant_log[$];

  initial forever begin
    @(posedge clk);
    model_valid = 1'b1;
    rst_ok      = (reset === 1'b1);
    if (!rst_ok) begin
      {e_mem_req, e_mem_we, e_ic_ack, e_dc_ack} = '0;
      e_mem_addr = '0; e_mem_wdata = '0; e_ic_rdata = '0; e_dc_rdata = '0;
      busy = 1'b0; t = 0; last_who = GRANT_IC;
    end else begin
      e_ic_ack = 1'b0;
      e_dc_ack = 1'b0;
      if (busy) begin
        t++;
        if (t == LAT) begin
          e_mem_req = 1'b0;
          e_mem_we  = 1'b0;
          if (cur_who == GRANT_DC) begin
            e_dc_ack = 1'b1;
            if (!cur_we) e_dc_rdata = bus.mem_rdata;
          end else begin
            e_ic_ack   = 1'b1;
            e_ic_rdata = bus.mem_rdata;
          end
        end else if (t == LAT + 1) begin
          busy = 1'b0;
        end
      end else if (bus.ic_req || bus.dc_req) begin
        if (bus.ic_req && bus.dc_req) cur_who = (last_who == GRANT_IC) ? GRANT_DC : GRANT_IC;
        else                          cur_who = bus.dc_req ? GRANT_DC : GRANT_IC;
        last_who = cur_who;
        grant_log.push_back(cur_who);
        busy = 1'b1; t = 0; e_mem_req = 1'b1;
        if (cur_who == GRANT_DC) begin
          cur_we = bus.dc_we; e_mem_we = bus.dc_we;
          e_mem_addr = bus.dc_addr; e_mem_wdata = bus.dc_wdata;
        end else begin
          cur_we = 1'b0; e_mem_we = 1'b0;
          e_mem_addr = bus.ic_addr; e_mem_wdata = '0;
        end
      end
    end
  end

  // Per-cycle comparison, plus the MEM_LATENCY=1 instance: each mem_req pulse
  // is one cycle long and is immediately followed by an ack.
  bit prev1 = 1'b0;
  initial forever begin
    @(negedge clk);
    if (model_valid) begin
      chk1("mem_req",  bus.mem_req, e_mem_req);
      chk1("mem_we",   bus.mem_we,  e_mem_we);
      chk("mem_addr",  128'(bus.mem_addr), 128'(e_mem_addr));
      chk("mem_wdata", bus.mem_wdata, e_mem_wdata);
      chk1("ic_ack",   bus.ic_ack,  e_ic_ack);
      chk1("dc_ack",   bus.dc_ack,  e_dc_ack);
      chk("ic_rdata",  bus.ic_rdata, e_ic_rdata);
      chk("dc_rdata",  bus.dc_rdata, e_dc_rdata);
      if (!rst_ok) prev1 = 1'b0;
      if (prev1) begin
        chk1("lat1_mem_req_len", bus1.mem_req, 1'b0);
        chk1("lat1_ack_follows", bus1.ic_ack | bus1.dc_ack, 1'b1);
      end
      prev1 = (bus1.mem_req === 1'b1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  bit            auto_drop = 1'b1;
  bit            ic_dropped, dc_dropped;
  bit            rd_fixed_en = 1'b0;
  logic [LW-1:0] rd_fixed;

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Advance one edge; caches drop req on the edge where they saw their ack.
  task automatic tick();
    logic ic_seen, dc_seen;
    ic_seen = bus.ic_ack;
    dc_seen = bus.dc_ack;
    @(posedge clk);
    #1;
    ic_dropped = 1'b0;
    dc_dropped = 1'b0;
    if (auto_drop && ic_seen === 1'b1) begin bus.ic_req = 1'b0; ic_dropped = 1'b1; end
    if (auto_drop && dc_seen === 1'b1) begin bus.dc_req = 1'b0; dc_dropped = 1'b1; end
    bus.mem_rdata = rd_fixed_en ? rd_fixed : rand_line();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || bus.ic_req || bus.dc_req) && n < 100) begin tick(); n++; end
    chk1("wait_idle_in_time", (n < 100), 1'b1);
  endtask

  initial begin
    int n, log_start, cnt, good, acks, ack_at, dacks;
    logic [LW-1:0] prior;

    // Reset held with both requests pending.
    reset = 1'b0;
    bus.ic_req = 1'b1; bus.ic_addr = 32'h40;
    bus.dc_req = 1'b1; bus.dc_we = 1'b0; bus.dc_addr = 32'h200; bus.dc_wdata = rand_line();
    bus.mem_rdata = '0;
    auto_drop = 1'b0;
    repeat (3) tick();
    chk1("reset_mem_req", bus.mem_req, 1'b0);
    chk("reset_ic_rdata", bus.ic_rdata, '0);
    reset = 1'b1;
    tick();
    chk1("first_grant_mem_req", bus.mem_req, 1'b1);
    chk("first_grant_is_dc", 128'(bus.mem_addr), 128'(32'h200));

    // Both requesters continuously pending: strict alternation from DC.
    log_start = grant_log.size() - 1;
    n = 0;
    while (grant_log.size() < log_start + 4 && n < 60) begin tick(); n++; end
    chk1("rr_four_grants_in_time", (n < 60), 1'b1);
    if (grant_log.size() >= log_start + 4) begin
      chk1("rr_grant0", grant_log[log_start],     GRANT_DC);
      chk1("rr_grant1", grant_log[log_start + 1], GRANT_IC);
      chk1("rr_grant2", grant_log[log_start + 2], GRANT_DC);
      chk1("rr_grant3", grant_log[log_start + 3], GRANT_IC);
    end
    auto_drop = 1'b1;
    wait_idle();

    // Single icache read.
    rd_fixed_en = 1'b1;
    rd_fixed = 128'hDEADBEEF_00000000_00000000_00000001;
    bus.ic_addr = 32'h0000_0040; bus.ic_req = 1'b1;
    cnt = 0; good = 0; acks = 0; ack_at = 0; dacks = 0;
    for (int j = 1; j <= 8; j++) begin
      tick();
      if (bus.mem_req) begin cnt++; if (!bus.mem_we) good++; end
      if (bus.ic_ack) begin acks++; ack_at = j; end
      if (bus.dc_ack) dacks++;
    end
    chk_int("ic_mem_req_cycles", cnt, 5);
    chk_int("ic_mem_we_low_cycles", good, 5);
    chk_int("ic_ack_count", acks, 1);
    chk_int("ic_ack_offset", ack_at, 6);
    chk_int("ic_no_dc_ack", dacks, 0);
    chk("ic_rdata_line", bus.ic_rdata, 128'hDEADBEEF_00000000_00000000_00000001);
    wait_idle();

    // Dcache write-back leaves dc_rdata alone.
    prior = e_dc_rdata;
    bus.dc_we = 1'b1; bus.dc_addr = 32'h100; bus.dc_wdata = {16{8'hA5}}; bus.dc_req = 1'b1;
    cnt = 0; good = 0; acks = 0;
    for (int j = 1; j <= 8; j++) begin
      tick();
      if (bus.mem_req) begin
        cnt++;
        if (bus.mem_we && bus.mem_addr == 32'h100 && bus.mem_wdata == {16{8'hA5}}) good++;
      end
      if (bus.dc_ack) acks++;
    end
    chk_int("wb_mem_req_cycles", cnt, 5);
    chk_int("wb_bus_fields_cycles", good, 5);
    chk_int("wb_dc_ack_count", acks, 1);
    chk("wb_dc_rdata_kept", bus.dc_rdata, prior);
    bus.dc_we = 1'b0;
    wait_idle();

    // Icache request arrives during a dcache read.
    rd_fixed = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    bus.dc_addr = 32'h300; bus.dc_req = 1'b1;
    repeat (3) tick();
    bus.ic_addr = 32'h80; bus.ic_req = 1'b1;
    for (int j = 4; j <= 8; j++) begin
      tick();
      if (j == 6) begin
        chk1("mid_dc_ack", bus.dc_ack, 1'b1);
        chk1("mid_no_ic_ack", bus.ic_ack, 1'b0);
        chk("mid_dc_rdata", bus.dc_rdata, 128'h01234567_89ABCDEF_FEDCBA98_76543210);
      end
      if (j == 7) chk1("mid_idle_gap", bus.mem_req, 1'b0);
      if (j == 8) begin
        chk1("mid_ic_granted", bus.mem_req, 1'b1);
        chk("mid_ic_addr", 128'(bus.mem_addr), 128'(32'h80));
      end
    end
    wait_idle();

    // Reset during the third ACCESS cycle drops the transaction.
    rd_fixed = 128'h11112222_33334444_55556666_77778888;
    bus.dc_addr = 32'h400; bus.dc_req = 1'b1;
    acks = 0; ack_at = 0;
    for (int j = 1; j <= 12; j++) begin
      if (j == 4) reset = 1'b0;
      tick();
      if (j == 4) begin
        reset = 1'b1;
        chk1("rst_mid_mem_req", bus.mem_req, 1'b0);
        chk("rst_mid_dc_rdata", bus.dc_rdata, '0);
      end
      if (bus.dc_ack) begin acks++; ack_at = j; end
    end
    chk_int("rst_mid_ack_count", acks, 1);
    chk_int("rst_mid_ack_offset", ack_at, 10);
    chk("rst_mid_reserved_rdata", bus.dc_rdata, 128'h11112222_33334444_55556666_77778888);
    wait_idle();

    // Random traffic with occasional resets.
    rd_fixed_en = 1'b0;
    for (int k = 0; k < 800; k++) begin
      if (!bus.ic_req && !ic_dropped && $urandom_range(2) == 0) bus.ic_req = 1'b1;
      if (!bus.dc_req && !dc_dropped && $urandom_range(2) == 0) begin
        bus.dc_req = 1'b1;
        bus.dc_we  = $urandom_range(1) == 1;
      end
      bus.ic_addr  = $urandom & 32'hFFFF_FFF0;
      bus.dc_addr  = $urandom & 32'hFFFF_FFF0;
      bus.dc_wdata = rand_line();
      if ($urandom_range(250) == 0) reset = 1'b0;
      tick();
      reset = 1'b1;
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
